// File: rtl/video_stream_checker_pkg.sv
// ---------------------------------------------------------------------------
// video_stream_pkg
//   Shared types and constants for the video stream checker.
//   - vsc_state_e : checker FSM states (hunting for SOF / inside a frame)
//   - sum_width() : width of the per-frame pixel accumulator
//   - LFSR_SEED / LFSR_TAPS : backpressure LFSR reset value and feedback taps
//     (taps 16,14,13,11 -> bit positions 15,13,12,10)
// ---------------------------------------------------------------------------
package video_stream_pkg;

  typedef enum logic [0:0] {
    WAIT_SOF = 1'b0,
    IN_FRAME = 1'b1
  } vsc_state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // w*h pixels of at most 2^data_width-1 each always fit in this width.
  function automatic int sum_width(input int data_width, input int w, input int h);
    return data_width + $clog2(w * h);
  endfunction

endpackage

// File: rtl/video_stream_checker_if.sv
// ---------------------------------------------------------------------------
// video_stream_checker_if
//   AXI4-Stream video beat bundle.
//   tdata  : pixel
//   tvalid : beat valid
//   tlast  : end of line
//   tuser  : start of frame
//   tready : sink ready
//   master modport drives the beat, slave modport drives tready.
// ---------------------------------------------------------------------------
interface video_stream_checker_if #(
  parameter int DATA_WIDTH = 8
) ();

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;
  logic                  tuser;
  logic                  tready;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    output tuser,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    input  tuser,
    output tready
  );

endinterface

// File: rtl/video_stream_checker_lfsr16.sv
// ---------------------------------------------------------------------------
// lfsr16
//   16-bit Fibonacci LFSR (taps 16,14,13,11) advancing every cycle, used to
//   generate pseudo-random stall cycles on the checker's tready.
//   clk : clock
//   rst : asynchronous active-high reset, loads LFSR_SEED
//   q   : current LFSR state
// ---------------------------------------------------------------------------
module lfsr16
  import video_stream_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  logic fb;

  assign fb = ^(q & LFSR_TAPS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= LFSR_SEED;
    end else begin
      q <= {q[14:0], fb};
    end
  end

endmodule

// File: rtl/video_stream_checker.sv
// ---------------------------------------------------------------------------
// video_stream_checker
//   AXI4-Stream video sink. Checks frame geometry (FRAME_WIDTH x FRAME_HEIGHT)
//   and framing markers (tuser = SOF, tlast = EOL), accumulates a per-frame
//   pixel sum and reports every completed or aborted frame.
//
//   Ports:
//     clk, rst          : clock, asynchronous active-high reset
//     s_axis (slave)    : incoming pixel stream, tready driven here
//     err_clr           : clears the sticky error flags
//     frame_done        : one-cycle pulse per reported frame
//     frame_ok          : last reported frame had no errors
//     frame_sum         : pixel sum of last reported frame
//     frame_count       : frames reported (wraps)
//     drop_count        : beats dropped while hunting for SOF (saturates)
//     err_sof           : sticky, tuser seen mid-frame
//     err_early_eol     : sticky, tlast before last column
//     err_late_eol      : sticky, tlast missing on last column
//
//   Build option: VIDEO_CHECKER_BACKPRESSURE_EN adds LFSR-driven stalls on
//   tready (about one stall cycle in sixteen).
// ---------------------------------------------------------------------------
module video_stream_checker
  import video_stream_pkg::*;
#(
  parameter  int DATA_WIDTH   = 8,
  parameter  int FRAME_WIDTH  = 640,
  parameter  int FRAME_HEIGHT = 512,
  localparam int SUM_WIDTH    = sum_width(DATA_WIDTH, FRAME_WIDTH, FRAME_HEIGHT)
) (
  input  logic                 clk,
  input  logic                 rst,
  video_stream_checker_if.slave s_axis,
  input  logic                 err_clr,
  output logic                 frame_done,
  output logic                 frame_ok,
  output logic [SUM_WIDTH-1:0] frame_sum,
  output logic [15:0]          frame_count,
  output logic [15:0]          drop_count,
  output logic                 err_sof,
  output logic                 err_early_eol,
  output logic                 err_late_eol
);

  localparam int HCNT_W = $clog2(FRAME_WIDTH);
  localparam int VCNT_W = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
  localparam logic [HCNT_W-1:0] H_LAST = HCNT_W'(FRAME_WIDTH - 1);
  localparam logic [VCNT_W-1:0] V_LAST = VCNT_W'(FRAME_HEIGHT - 1);

  vsc_state_e            state, state_n;
  logic [HCNT_W-1:0]     hcnt, hcnt_n;
  logic [VCNT_W-1:0]     vcnt, vcnt_n;
  logic [SUM_WIDTH-1:0]  sum, sum_n, sum_acc;
  logic                  ferr, ferr_n;
  logic                  ready_q;
  logic                  accept;
  logic                  report, report_ok;
  logic [SUM_WIDTH-1:0]  report_sum;
  logic                  set_sof, set_early, set_late;
  logic                  drop_inc;
  logic                  line_end;
  logic [SUM_WIDTH-1:0]  pix;

  assign pix     = SUM_WIDTH'(s_axis.tdata);
  assign sum_acc = sum + pix;

  // ready_q holds tready low through reset and the release cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
    end
  end

`ifdef VIDEO_CHECKER_BACKPRESSURE_EN
  logic [15:0] lfsr_q;

  lfsr16 u_lfsr16 (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_q)
  );

  assign s_axis.tready = ready_q && (lfsr_q[3:0] != 4'h0);
`else
  assign s_axis.tready = ready_q;
`endif

  assign accept = s_axis.tvalid && s_axis.tready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= WAIT_SOF;
      hcnt  <= '0;
      vcnt  <= '0;
      sum   <= '0;
      ferr  <= 1'b0;
    end else begin
      state <= state_n;
      hcnt  <= hcnt_n;
      vcnt  <= vcnt_n;
      sum   <= sum_n;
      ferr  <= ferr_n;
    end
  end

  always_comb begin
    state_n    = state;
    hcnt_n     = hcnt;
    vcnt_n     = vcnt;
    sum_n      = sum;
    ferr_n     = ferr;
    report     = 1'b0;
    report_ok  = 1'b0;
    report_sum = sum;
    set_sof    = 1'b0;
    set_early  = 1'b0;
    set_late   = 1'b0;
    drop_inc   = 1'b0;
    line_end   = 1'b0;

    if (accept) begin
      if (s_axis.tuser) begin
        // SOF restarts the frame; mid-frame it first reports the partial
        // frame (sum excludes this beat) as aborted.
        if (state == IN_FRAME) begin
          report     = 1'b1;
          report_ok  = 1'b0;
          report_sum = sum;
          set_sof    = 1'b1;
        end
        sum_n   = pix;
        hcnt_n  = HCNT_W'(1);
        vcnt_n  = '0;
        ferr_n  = 1'b0;
        state_n = IN_FRAME;
      end else if (state == WAIT_SOF) begin
        drop_inc = 1'b1;
      end else begin
        sum_n = sum_acc;
        if (s_axis.tlast && (hcnt < H_LAST)) begin
          set_early = 1'b1;
          line_end  = 1'b1;
        end else if (!s_axis.tlast && (hcnt == H_LAST)) begin
          // Forced wrap keeps the line grid aligned despite the missing tlast.
          set_late = 1'b1;
          line_end = 1'b1;
        end else if (s_axis.tlast) begin
          line_end = 1'b1;
        end else begin
          hcnt_n = hcnt + HCNT_W'(1);
        end

        ferr_n = ferr || set_early || set_late;

        if (line_end) begin
          hcnt_n = '0;
          if (vcnt == V_LAST) begin
            report     = 1'b1;
            report_ok  = !(ferr || set_early || set_late);
            report_sum = sum_acc;
            state_n    = WAIT_SOF;
          end else begin
            vcnt_n = vcnt + VCNT_W'(1);
          end
        end
      end
    end
  end

  // Registered reporting and sticky flags; a new error beats err_clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_done    <= 1'b0;
      frame_ok      <= 1'b0;
      frame_sum     <= '0;
      frame_count   <= '0;
      drop_count    <= '0;
      err_sof       <= 1'b0;
      err_early_eol <= 1'b0;
      err_late_eol  <= 1'b0;
    end else begin
      frame_done <= report;
      if (report) begin
        frame_ok    <= report_ok;
        frame_sum   <= report_sum;
        frame_count <= frame_count + 16'd1;
      end
      if (drop_inc && (drop_count != 16'hFFFF)) begin
        drop_count <= drop_count + 16'd1;
      end
      err_sof       <= set_sof   || (err_sof       && !err_clr);
      err_early_eol <= set_early || (err_early_eol && !err_clr);
      err_late_eol  <= set_late  || (err_late_eol  && !err_clr);
    end
  end

endmodule
